// File: rtl/ram2_arbiter.sv
// RAM2 asynchronous SRAM sequencer shared by bootloader init writes, EXE load/store and IF fetch.
// Fixed priority init > exe > if; every output comes straight from a register.
module ram2_arbiter #(
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_PULSE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic [17:0] init_addr,
  input  logic [15:0] init_wdata,
  output logic        init_done,
  input  logic        exe_req,
  input  logic        exe_wr,
  input  logic [17:0] exe_addr,
  input  logic [15:0] exe_wdata,
  output logic        exe_done,
  input  logic        if_req,
  input  logic [17:0] if_addr,
  output logic        if_done,
  output logic [15:0] rdata,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_en_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SU, S_WR_PL, S_WR_HD, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_INIT = 2'd1, OWN_EXE = 2'd2, OWN_IF = 2'd3} owner_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        en_n_q, en_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        busy_q, busy_d;
  logic [1:0]  grant_q, grant_d;
  logic        init_done_q, init_done_d;
  logic        exe_done_q, exe_done_d;
  logic        if_done_q, if_done_d;
  logic        start_wr;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    start_wr = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        owner_d = OWN_NONE;
        if (init_req) begin
          owner_d  = OWN_INIT;
          addr_d   = init_addr;
          wdata_d  = init_wdata;
          start_wr = 1'b1;
        end else if (exe_req) begin
          owner_d  = OWN_EXE;
          addr_d   = exe_addr;
          wdata_d  = exe_wdata;
          start_wr = exe_wr;
        end else if (if_req) begin
          owner_d  = OWN_IF;
          addr_d   = if_addr;
        end
        if (owner_d != OWN_NONE) begin
          state_d = start_wr ? S_WR_SU : S_RD;
          cnt_d   = RD_LOAD;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d = sram_dq_i;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SU: begin
        state_d = S_WR_PL;
        cnt_d   = WR_LOAD;
      end
      S_WR_PL: begin
        if (cnt_q == 4'd0) state_d = S_WR_HD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_HD: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin levels are decoded from the next state so they register alongside it.
    en_n_d      = !(state_d inside {S_RD, S_WR_SU, S_WR_PL, S_WR_HD});
    oe_n_d      = (state_d != S_RD);
    we_n_d      = (state_d != S_WR_PL);
    dq_oe_d     = (state_d inside {S_WR_SU, S_WR_PL, S_WR_HD});
    busy_d      = (state_d != S_IDLE);
    grant_d     = (state_d == S_IDLE) ? 2'd0 : owner_d;
    init_done_d = (state_d == S_DONE) && (owner_d == OWN_INIT);
    exe_done_d  = (state_d == S_DONE) && (owner_d == OWN_EXE);
    if_done_d   = (state_d == S_DONE) && (owner_d == OWN_IF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      init_done_q <= 1'b0;
      exe_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      en_n_q      <= en_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      init_done_q <= init_done_d;
      exe_done_q  <= exe_done_d;
      if_done_q   <= if_done_d;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_en_n  = en_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign rdata      = rdata_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign init_done  = init_done_q;
  assign exe_done   = exe_done_q;
  assign if_done    = if_done_q;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed + randomized bench for ram2_arbiter against a transaction-level memory/priority model.
// A second instance built with RD_WAIT=4, WR_PULSE=1 checks the parameterised timing.
module tb_ram2_arbiter;

  localparam int unsigned RDW = 2;
  localparam int unsigned WRP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req, exe_req, exe_wr, if_req;
  logic [17:0] init_addr, exe_addr, if_addr;
  logic [15:0] init_wdata, exe_wdata;
  logic        init_done, exe_done, if_done;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic        busy;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_en_n, sram_oe_n, sram_we_n;

  logic        b_exe_req, b_exe_wr, b_if_req;
  logic [17:0] b_exe_addr, b_if_addr;
  logic [15:0] b_exe_wdata;
  logic        b_init_done, b_exe_done, b_if_done;
  logic [15:0] b_rdata;
  logic [1:0]  b_grant;
  logic        b_busy;
  logic [17:0] b_sram_addr;
  logic [15:0] b_sram_dq_o;
  logic        b_sram_dq_oe, b_sram_en_n, b_sram_oe_n, b_sram_we_n;

  logic [15:0] sram_mem [64];
  logic [15:0] ref_mem  [64];
  logic [15:0] exp_rdata;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  ram2_arbiter #(.RD_WAIT(RDW), .WR_PULSE(WRP)) u_dut (
    .clk(clk), .rst(rst),
    .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata), .init_done(init_done),
    .exe_req(exe_req), .exe_wr(exe_wr), .exe_addr(exe_addr), .exe_wdata(exe_wdata), .exe_done(exe_done),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .rdata(rdata), .grant(grant), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_en_n(sram_en_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  ram2_arbiter #(.RD_WAIT(4), .WR_PULSE(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .init_req(1'b0), .init_addr(18'h0), .init_wdata(16'h0), .init_done(b_init_done),
    .exe_req(b_exe_req), .exe_wr(b_exe_wr), .exe_addr(b_exe_addr), .exe_wdata(b_exe_wdata), .exe_done(b_exe_done),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done),
    .rdata(b_rdata), .grant(b_grant), .busy(b_busy),
    .sram_addr(b_sram_addr), .sram_dq_o(b_sram_dq_o), .sram_dq_oe(b_sram_dq_oe), .sram_dq_i(16'h5EED),
    .sram_en_n(b_sram_en_n), .sram_oe_n(b_sram_oe_n), .sram_we_n(b_sram_we_n)
  );

  // Pin-level SRAM: drives data while OE is low, stores on edges where WE is low.
  assign sram_dq_i = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[5:0]];
  always @(posedge clk)
    if (!sram_en_n && !sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] rand_addr();
    logic [17:0] a;
    a = 18'($urandom_range(0, 63));
    if ($urandom_range(0, 3) == 0) a = a | 18'h3FFC0;
    return a;
  endfunction

  task automatic drop_req(input int owner);
    case (owner)
      1: init_req = 1'b0;
      2: exe_req  = 1'b0;
      default: if_req = 1'b0;
    endcase
  endtask

  // Called during an IDLE cycle with the owner's request already presented; the first
  // edge is the accepting edge. Ends one cycle into the following IDLE cycle.
  // mode: 0 none, 1 scramble owner inputs, 2 raise exe_req, 3 drop owner req mid-transfer.
  task automatic expect_txn(input int owner, input bit wr, input logic [17:0] a,
                            input logic [15:0] d, input int mode, input bit keep);
    int lat;
    bit last;
    logic [3:0] pins;
    lat = wr ? int'(WRP) + 3 : int'(RDW) + 1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      last = (k == lat);
      if (k == 1) begin
        if (mode == 1) begin
          case (owner)
            1: begin init_addr = rand_addr(); init_wdata = 16'($urandom); end
            2: begin exe_addr = rand_addr(); exe_wdata = 16'($urandom); exe_wr = ~exe_wr; end
            default: if_addr = rand_addr();
          endcase
        end else if (mode == 2) exe_req = 1'b1;
        else if (mode == 3) drop_req(owner);
      end
      if (last && !wr) exp_rdata = ref_mem[a[5:0]];
      if (last)      pins = 4'b1110;
      else if (!wr)  pins = 4'b0010;
      else           pins = {1'b0, 1'b1, !(k >= 2 && k <= int'(WRP) + 1), 1'b1};
      chk("grant", 32'(grant), 32'(owner));
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'({init_done, exe_done, if_done}),
          last ? 32'(3'b100 >> (owner - 1)) : 32'd0);
      chk("pins", 32'({sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'(pins));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      if (!last) chk("addr", 32'(sram_addr), 32'(a));
      if (!last && wr) chk("dq_o", 32'(sram_dq_o), 32'(d));
      if (last && !keep) drop_req(owner);
    end
    if (wr) ref_mem[a[5:0]] = d;
    @(posedge clk); #1;
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'({init_done, exe_done, if_done}), 32'd0);
    chk("idle_pins", 32'({sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'hE);
  endtask

  task automatic measure2(input bit wr, output int lat, output int low);
    lat = 0;
    low = 0;
    if (wr) b_exe_req = 1'b1; else b_if_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (wr ? !b_sram_we_n : !b_sram_oe_n) low++;
      if (wr ? b_exe_done : b_if_done) begin
        lat = k;
        break;
      end
    end
    b_exe_req = 1'b0;
    b_if_req  = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int owner, lat2, low2;
    bit wr;
    logic [17:0] a;
    logic [15:0] d;
    logic [2:0] r;

    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = 16'(i) * 16'h0101 ^ 16'h3C3C;
      ref_mem[i]  = 16'(i) * 16'h0101 ^ 16'h3C3C;
    end
    sram_mem[16] = 16'hABCD;
    ref_mem[16]  = 16'hABCD;
    exp_rdata = 16'h0000;
    rst = 1'b1;
    {init_req, exe_req, exe_wr, if_req} = '0;
    init_addr = '0; exe_addr = '0; if_addr = '0; init_wdata = '0; exe_wdata = '0;
    {b_exe_req, b_exe_wr, b_if_req} = '0;
    b_exe_addr = 18'h00123; b_if_addr = 18'h00456; b_exe_wdata = 16'h9999;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pins", 32'({sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'hE);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ctl", 32'({grant, busy, init_done, exe_done, if_done}), 32'd0);
    chk("rst_b_ctl", 32'({b_grant, b_busy, b_sram_en_n, b_sram_we_n}), 32'h3);
    rst = 1'b0;

    // Single fetch, then single EXE store.
    if_req = 1'b1; if_addr = 18'h00010;
    expect_txn(3, 1'b0, 18'h00010, 16'h0, 0, 1'b0);
    exe_req = 1'b1; exe_wr = 1'b1; exe_addr = 18'h0BF00; exe_wdata = 16'h1234;
    expect_txn(2, 1'b1, 18'h0BF00, 16'h1234, 0, 1'b0);

    // All three at once: init -> exe -> if.
    init_req = 1'b1; init_addr = 18'h00005; init_wdata = 16'hC0DE;
    exe_req = 1'b1; exe_wr = 1'b0; exe_addr = 18'h00005;
    if_req = 1'b1; if_addr = 18'h0BF00;
    expect_txn(1, 1'b1, 18'h00005, 16'hC0DE, 0, 1'b0);
    expect_txn(2, 1'b0, 18'h00005, 16'h0, 0, 1'b0);
    expect_txn(3, 1'b0, 18'h0BF00, 16'h0, 0, 1'b0);

    // Continuous fetch; EXE raised mid-fetch wins the next IDLE.
    if_req = 1'b1; if_addr = 18'h00021;
    expect_txn(3, 1'b0, 18'h00021, 16'h0, 0, 1'b1);
    exe_wr = 1'b0; exe_addr = 18'h00022;
    expect_txn(3, 1'b0, 18'h00021, 16'h0, 2, 1'b1);
    expect_txn(2, 1'b0, 18'h00022, 16'h0, 0, 1'b0);
    expect_txn(3, 1'b0, 18'h00021, 16'h0, 0, 1'b0);

    // Reset in the middle of the write pulse.
    exe_req = 1'b1; exe_wr = 1'b1; exe_addr = 18'h00030; exe_wdata = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_we", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_rdata = 16'h0000;
    chk("rst_mid_pins", 32'({sram_en_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'hE);
    chk("rst_mid_ctl", 32'({grant, busy, init_done, exe_done, if_done}), 32'd0);
    chk("rst_mid_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    expect_txn(2, 1'b1, 18'h00030, 16'h7777, 0, 1'b0);
    if_req = 1'b1; if_addr = 18'h00030;
    expect_txn(3, 1'b0, 18'h00030, 16'h0, 0, 1'b0);

    // Randomised request mixes, each served in priority order.
    for (int it = 0; it < 30; it++) begin
      r = 3'($urandom_range(1, 7));
      init_req = r[0]; init_addr = rand_addr(); init_wdata = 16'($urandom);
      exe_req = r[1]; exe_wr = 1'($urandom); exe_addr = rand_addr(); exe_wdata = 16'($urandom);
      if_req = r[2]; if_addr = rand_addr();
      while (init_req || exe_req || if_req) begin
        if (init_req)     begin owner = 1; wr = 1'b1;   a = init_addr; d = init_wdata; end
        else if (exe_req) begin owner = 2; wr = exe_wr; a = exe_addr;  d = exe_wdata;  end
        else              begin owner = 3; wr = 1'b0;   a = if_addr;   d = 16'h0;      end
        expect_txn(owner, wr, a, d, $urandom_range(0, 3), 1'b0);
      end
    end

    // Alternate build: RD_WAIT=4, WR_PULSE=1.
    b_exe_wr = 1'b1;
    measure2(1'b1, lat2, low2);
    chk("b_wr_lat", 32'(lat2), 32'd4);
    chk("b_we_low", 32'(low2), 32'd1);
    measure2(1'b0, lat2, low2);
    chk("b_rd_lat", 32'(lat2), 32'd5);
    chk("b_oe_low", 32'(low2), 32'd4);
    chk("b_rdata", 32'(b_rdata), 32'h5EED);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
